// File: rtl/processed_data_collector.sv
// Collector FIFO at the tail of the sensor pipeline: captures valid-only words,
// serves them over ready/valid, and drops and counts words that arrive while full.
module processed_data_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic                  out_ready,
    input  logic                  clear_overflow,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic [CNT_W-1:0]      level,
    output logic                  overflow,
    output logic [7:0]            drop_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            drop_count_q, drop_count_d;

    logic full, pop, push, drop;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the incoming word.
    assign full = (level_q == CNT_W'(DEPTH));
    assign pop  = (level_q != '0) && out_ready;
    assign push = valid_in && (!full || pop);
    assign drop = valid_in && full && !pop;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + CNT_W'(1);
            2'b01:   level_d = level_q - CNT_W'(1);
            default: level_d = level_q;
        endcase

        // A drop coinciding with a clear counts as the first drop after the clear.
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_overflow) begin
                drop_count_d = 8'd1;
            end else if (drop_count_q != 8'hFF) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end else if (clear_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign out_data   = mem_q[rd_ptr_q];
    assign out_valid  = (level_q != '0);
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule
